// File: rtl/mips_bus_pkg.sv
// mips_bus_pkg: shared bus state enum, word/lane widths, reset vector and wait-LFSR tap mask
package mips_bus_pkg;
  typedef enum logic {IDLE, WAIT} bus_state_t;
  localparam int WORD_W = 32;
  localparam int BE_W = 4;
  localparam logic [WORD_W-1:0] RESET_VECTOR = 32'hBFC00000;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
endpackage

// File: rtl/mips_bus_wait_lfsr.sv
// mips_bus_wait_lfsr: 16-bit Fibonacci LFSR (taps 16,14,13,11); in clk reset seed adv, out state
module mips_bus_wait_lfsr
  import mips_bus_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] seed,
  input  logic        adv,
  output logic [15:0] state
);
  always_ff @(posedge clk)
    if (reset) state <= seed;
    else if (adv) state <= {state[14:0], ^(state & LFSR_TAPS)};
endmodule

// File: rtl/mips_bus_mem_model.sv
// mips_bus_mem_model: ROM/RAM bus slave with wait states, byte lanes, sticky fault, transfer count; in clk reset address read write writedata byteenable, out waitrequest readdata fault xfer_count; MIPS_BUS_RANDOM_WAIT_EN selects LFSR wait counts
module mips_bus_mem_model
  import mips_bus_pkg::*;
#(
  parameter logic [31:0] ROM_BASE = RESET_VECTOR,
  parameter int ROM_DEPTH = 256,
  parameter logic [31:0] RAM_BASE = 32'h00000000,
  parameter int RAM_DEPTH = 1024,
  parameter int WAIT_CYCLES = 0,
  parameter string ROM_INIT_FILE = "",
  parameter string RAM_INIT_FILE = "",
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       address,
  input  logic              write,
  input  logic              read,
  output logic              waitrequest,
  input  logic [WORD_W-1:0] writedata,
  input  logic [BE_W-1:0]   byteenable,
  output logic [WORD_W-1:0] readdata,
  output logic              fault,
  output logic [31:0]       xfer_count
);
  localparam int RA = ROM_DEPTH > 1 ? $clog2(ROM_DEPTH) : 1;
  localparam int WA = RAM_DEPTH > 1 ? $clog2(RAM_DEPTH) : 1;
  typedef logic [WORD_W-1:0] rom_t [ROM_DEPTH];
  typedef logic [WORD_W-1:0] ram_t [RAM_DEPTH];
  rom_t rom = '{default: '0};
  ram_t ram = '{default: '0};
  bus_state_t state, state_n;
  logic [3:0] cnt, cnt_n, nwait;
  logic [31:0] rom_off, ram_off, lat_addr;
  logic [WORD_W-1:0] word, rd_hold;
  logic rom_hit, ram_hit, req, err, done, viol, lat_rd, lat_wr;
  assign req = read | write;
  assign rom_off = address - ROM_BASE;
  assign ram_off = address - RAM_BASE;
  assign rom_hit = address >= ROM_BASE && (rom_off >> 2) < 32'(ROM_DEPTH);
  assign ram_hit = address >= RAM_BASE && (ram_off >> 2) < 32'(RAM_DEPTH);
  assign err = (read & write) | (|address[1:0]) | ~(rom_hit | ram_hit) | (write & rom_hit);
  assign word = rom_hit ? rom[rom_off[RA+1:2]] : ram[ram_off[WA+1:2]];
  assign viol = state == WAIT && {address, read, write} != {lat_addr, lat_rd, lat_wr};
`ifdef MIPS_BUS_RANDOM_WAIT_EN
  logic [15:0] lfsr;
  logic [4:0] wmod;
  assign wmod = 5'(WAIT_CYCLES + 1);
  assign nwait = 4'({1'b0, lfsr[3:0]} % wmod);
  mips_bus_wait_lfsr u_lfsr (.clk(clk), .reset(reset), .seed(LFSR_SEED), .adv(done), .state(lfsr));
`else
  assign nwait = 4'(WAIT_CYCLES);
`endif
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    waitrequest = 1'b0;
    done = 1'b0;
    if (state == IDLE) begin
      if (req && !err && nwait != 4'd0) begin
        waitrequest = 1'b1;
        state_n = WAIT;
        cnt_n = nwait - 4'd1;
      end else done = req;
    end else if (cnt != 4'd0) begin
      waitrequest = 1'b1;
      cnt_n = cnt - 4'd1;
    end else begin
      done = 1'b1;
      state_n = IDLE;
    end
    readdata = (done && read) ? (err ? '0 : word) : rd_hold;
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      cnt <= 4'd0;
      fault <= 1'b0;
      xfer_count <= 32'd0;
      rd_hold <= '0;
      lat_addr <= 32'd0;
      lat_rd <= 1'b0;
      lat_wr <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      fault <= fault | (done & err) | viol;
      xfer_count <= xfer_count + 32'(done);
      if (done && read) rd_hold <= readdata;
      if (state == IDLE && state_n == WAIT) {lat_addr, lat_rd, lat_wr} <= {address, read, write};
    end
  always_ff @(posedge clk)
    if (!reset && done && write && !err)
      for (int i = 0; i < BE_W; i++)
        if (byteenable[i]) ram[ram_off[WA+1:2]][8*i +: 8] <= writedata[8*i +: 8];
endmodule

// File: tb/tb_mips_bus_mem_model.sv
// tb_mips_bus_mem_model: table-driven and sequence checks of the bus memory model on three instances
module tb_mips_bus_mem_model;
  import mips_bus_pkg::*;
  localparam int W1 = `ifdef MIPS_BUS_RANDOM_WAIT_EN 7 `else 3 `endif;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst [3];
  logic rd [3], wr [3], wq [3], flt [3];
  logic [31:0] addr [3], wd [3], rdat [3], cnt [3];
  logic [3:0] be [3];
  int checks = 0, failures = 0;
  mips_bus_mem_model #(.WAIT_CYCLES(0)) u0 (.clk(clk), .reset(rst[0]), .address(addr[0]), .write(wr[0]), .read(rd[0]),
    .waitrequest(wq[0]), .writedata(wd[0]), .byteenable(be[0]), .readdata(rdat[0]), .fault(flt[0]), .xfer_count(cnt[0]));
  mips_bus_mem_model #(.WAIT_CYCLES(W1)) u1 (.clk(clk), .reset(rst[1]), .address(addr[1]), .write(wr[1]), .read(rd[1]),
    .waitrequest(wq[1]), .writedata(wd[1]), .byteenable(be[1]), .readdata(rdat[1]), .fault(flt[1]), .xfer_count(cnt[1]));
  mips_bus_mem_model #(.WAIT_CYCLES(4)) u2 (.clk(clk), .reset(rst[2]), .address(addr[2]), .write(wr[2]), .read(rd[2]),
    .waitrequest(wq[2]), .writedata(wd[2]), .byteenable(be[2]), .readdata(rdat[2]), .fault(flt[2]), .xfer_count(cnt[2]));
  typedef struct {
    bit rs;
    logic r, w;
    logic [31:0] a, d;
    logic [3:0] b;
    bit crd;
    logic [31:0] erd;
    logic ef;
    logic [31:0] ec;
  } vec_t;
  vec_t tv [$];
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic do_reset(input int k);
    rst[k] = 1'b1;
    rd[k] = 1'b0;
    wr[k] = 1'b0;
    @(posedge clk);
    #1;
    rst[k] = 1'b0;
  endtask
  task automatic xfer(input int k, input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] b, input bit keep, output int st, output logic [31:0] q);
    addr[k] = a;
    wd[k] = d;
    be[k] = b;
    rd[k] = r;
    wr[k] = w;
    st = 0;
    #1;
    while (wq[k] && st < 40) begin
      st++;
      @(posedge clk);
      #1;
    end
    q = rdat[k];
    @(posedge clk);
    #1;
    if (!keep) begin
      rd[k] = 1'b0;
      wr[k] = 1'b0;
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    int st, n;
    logic [31:0] q;
    logic [15:0] s;
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; rd[k] = 1'b0; wr[k] = 1'b0; addr[k] = '0; wd[k] = '0; be[k] = '0;
    end
    @(posedge clk);
    #1;
    u0.rom[0] = 32'h8C030001;
    u0.rom[1] = 32'h24020005;
    u0.rom[255] = 32'hCAFE0255;
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;
    do_reset(0);
    #1;
    chk("reset waitrequest", 32'(wq[0]), 32'd0);
    chk("reset readdata", rdat[0], 32'd0);
    chk("reset fault", 32'(flt[0]), 32'd0);
    chk("reset xfer_count", cnt[0], 32'd0);
    tv.push_back(vec_t'{1, 1, 0, 32'hBFC00000, 32'h0, 4'h0, 1, 32'h8C030001, 0, 1});
    tv.push_back(vec_t'{0, 0, 1, 32'h00000000, 32'h11223344, 4'hF, 0, 32'h0, 0, 2});
    tv.push_back(vec_t'{0, 0, 1, 32'h00000000, 32'hDEADBEEF, 4'h5, 0, 32'h0, 0, 3});
    tv.push_back(vec_t'{0, 1, 0, 32'h00000000, 32'h0, 4'h0, 1, 32'h11AD33EF, 0, 4});
    tv.push_back(vec_t'{0, 0, 1, 32'h00000004, 32'hCAFEF00D, 4'h0, 0, 32'h0, 0, 5});
    tv.push_back(vec_t'{0, 1, 0, 32'h00000004, 32'h0, 4'hF, 1, 32'h00000000, 0, 6});
    tv.push_back(vec_t'{0, 0, 1, 32'hBFC00004, 32'hFFFFFFFF, 4'hF, 0, 32'h0, 1, 7});
    tv.push_back(vec_t'{0, 1, 0, 32'hBFC00004, 32'h0, 4'h0, 1, 32'h24020005, 1, 8});
    tv.push_back(vec_t'{1, 1, 0, 32'h00000002, 32'h0, 4'h0, 1, 32'h00000000, 1, 1});
    tv.push_back(vec_t'{1, 1, 1, 32'h00000000, 32'h0, 4'hF, 0, 32'h0, 1, 1});
    tv.push_back(vec_t'{1, 1, 0, 32'hBFC00000, 32'h0, 4'h0, 1, 32'h8C030001, 0, 1});
    tv.push_back(vec_t'{0, 1, 0, 32'h80000000, 32'h0, 4'h0, 1, 32'h00000000, 1, 2});
    tv.push_back(vec_t'{0, 1, 0, 32'h00000000, 32'h0, 4'h0, 1, 32'h11AD33EF, 1, 3});
    tv.push_back(vec_t'{1, 0, 1, 32'h00000FFC, 32'h00000077, 4'hF, 0, 32'h0, 0, 1});
    tv.push_back(vec_t'{0, 1, 0, 32'h00000FFC, 32'h0, 4'h0, 1, 32'h00000077, 0, 2});
    tv.push_back(vec_t'{0, 1, 0, 32'hBFC003FC, 32'h0, 4'h0, 1, 32'hCAFE0255, 0, 3});
    tv.push_back(vec_t'{0, 1, 0, 32'h00001000, 32'h0, 4'h0, 1, 32'h00000000, 1, 4});
    tv.push_back(vec_t'{0, 1, 0, 32'hBFC003FC, 32'h0, 4'h0, 1, 32'hCAFE0255, 1, 5});
    tv.push_back(vec_t'{0, 1, 0, 32'hBFC00400, 32'h0, 4'h0, 1, 32'h00000000, 1, 6});
    foreach (tv[i]) begin
      if (tv[i].rs) do_reset(0);
      xfer(0, tv[i].r, tv[i].w, tv[i].a, tv[i].d, tv[i].b, 0, st, q);
      chk($sformatf("v%0d stalls", i), 32'(st), 32'd0);
      if (tv[i].crd) chk($sformatf("v%0d readdata", i), q, tv[i].erd);
      chk($sformatf("v%0d fault", i), 32'(flt[0]), 32'(tv[i].ef));
      chk($sformatf("v%0d xfer_count", i), cnt[0], tv[i].ec);
    end
`ifdef MIPS_BUS_RANDOM_WAIT_EN
    do_reset(1);
    s = 16'hACE1;
    for (int i = 0; i < 100; i++) begin
      xfer(1, 1, 0, 32'(i % 16) * 4, 32'h0, 4'h0, 0, st, q);
      chk($sformatf("rand%0d stalls", i), 32'(st), 32'(s[3:0] % 4'd8));
      s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    end
    chk("rand xfer_count", cnt[1], 32'd100);
    chk("rand fault", 32'(flt[1]), 32'd0);
`else
    do_reset(1);
    xfer(1, 0, 1, 32'h4, 32'hA5A50004, 4'hF, 0, st, q);
    chk("w3 write4 stalls", 32'(st), 32'd3);
    xfer(1, 0, 1, 32'h8, 32'h00000008, 4'hF, 0, st, q);
    chk("w3 write8 stalls", 32'(st), 32'd3);
    xfer(1, 1, 0, 32'h4, 32'h0, 4'h0, 1, st, q);
    chk("w3 read4 stalls", 32'(st), 32'd3);
    chk("w3 read4 data", q, 32'hA5A50004);
    xfer(1, 1, 0, 32'h8, 32'h0, 4'h0, 0, st, q);
    chk("w3 b2b read8 stalls", 32'(st), 32'd3);
    chk("w3 b2b read8 data", q, 32'h00000008);
    #1;
    chk("w3 idle waitrequest", 32'(wq[1]), 32'd0);
    chk("w3 xfer_count", cnt[1], 32'd4);
    chk("w3 fault", 32'(flt[1]), 32'd0);
    addr[1] = 32'h4;
    rd[1] = 1'b1;
    @(posedge clk);
    #1;
    addr[1] = 32'h8;
    n = 0;
    #1;
    while (wq[1] && n < 40) begin
      n++;
      @(posedge clk);
      #1;
    end
    chk("viol data", rdat[1], 32'h00000008);
    @(posedge clk);
    #1;
    rd[1] = 1'b0;
    chk("viol fault", 32'(flt[1]), 32'd1);
    chk("viol xfer_count", cnt[1], 32'd5);
    do_reset(2);
    xfer(2, 0, 1, 32'h0, 32'h12345678, 4'hF, 0, st, q);
    chk("w4 write stalls", 32'(st), 32'd4);
    addr[2] = 32'h0;
    wd[2] = 32'h5A5A5A5A;
    be[2] = 4'hF;
    wr[2] = 1'b1;
    #1;
    chk("w4 stall1", 32'(wq[2]), 32'd1);
    @(posedge clk);
    #1;
    chk("w4 stall2", 32'(wq[2]), 32'd1);
    rst[2] = 1'b1;
    wr[2] = 1'b0;
    @(posedge clk);
    #1;
    rst[2] = 1'b0;
    #1;
    chk("abort waitrequest", 32'(wq[2]), 32'd0);
    chk("abort xfer_count", cnt[2], 32'd0);
    chk("abort fault", 32'(flt[2]), 32'd0);
    @(posedge clk);
    #1;
    xfer(2, 1, 0, 32'h0, 32'h0, 4'h0, 0, st, q);
    chk("abort read stalls", 32'(st), 32'd4);
    chk("abort read data", q, 32'h12345678);
    chk("abort read count", cnt[2], 32'd1);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
